// File: rtl/bus_arbiter_rr4_pkg.sv
// Shared types and constants for the 4-way round-robin write-bus arbiter.
// Requester indices name the fixed bus clients.
package bus_arbiter_rr4_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] ARB_REQ_ALU = 2'd0;
  localparam logic [1:0] ARB_REQ_LD  = 2'd1;
  localparam logic [1:0] ARB_REQ_CSR = 2'd2;
  localparam logic [1:0] ARB_REQ_DBG = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_arbiter_rr4_pick.sv
// Combinational round-robin picker: first unmasked requester after ptr,
// searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
module rr_priority_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] mask,
  output logic [1:0] pick_idx,
  output logic       pick_any
);

  logic [3:0] cand;
  logic [1:0] idx;

  assign cand = req & ~mask;

  // Walk the search order backwards so the nearest candidate is written last.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    idx      = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (cand[idx]) begin
        pick_idx = idx;
        pick_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr4.sv
// Round-robin arbiter for the shared write bus: registered one-hot grant,
// tenure bounded to MAX_HOLD beats, data mux of the granted requester.
//
//   state    | meaning
//   ARB_IDLE | no grant held; arbitrate any pending request from ptr
//   ARB_BUSY | grant_idx owns the bus; end tenure on drop, last or hold limit
module bus_arbiter_rr4
  import bus_arbiter_rr4_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [3:0]            last,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic [3:0]            grant,
  output logic [1:0]            grant_idx,
  output logic                  grant_valid,
  output logic [DATA_W-1:0]     bus_data,
  output logic                  bus_valid
);

  localparam int CNT_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic       busy;
  logic [1:0] pick_ptr;
  logic [3:0] pick_mask;
  logic [1:0] pick_idx;
  logic       pick_any;
  logic       end_drop, end_last, end_hold, tenure_end;

  assign busy = (state_q == ARB_BUSY);

  // Once busy, the current owner is both the rotation origin and excluded.
  assign pick_ptr  = busy ? grant_idx_q : ptr_q;
  assign pick_mask = busy ? onehot4(grant_idx_q) : 4'b0000;

  rr_priority_pick4 u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .mask     (pick_mask),
    .pick_idx (pick_idx),
    .pick_any (pick_any)
  );

  assign grant       = grant_valid_q ? onehot4(grant_idx_q) : 4'b0000;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign bus_valid   = grant_valid_q & req[grant_idx_q];

  always_comb begin
    bus_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant_valid_q && (grant_idx_q == 2'(i))) begin
        bus_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign end_drop   = ~req[grant_idx_q];
  assign end_last   = bus_valid & last[grant_idx_q];
  assign end_hold   = bus_valid & (beat_cnt_q == HOLD_LAST);
  assign tenure_end = busy & (end_drop | end_last | end_hold);

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    ptr_d         = ptr_q;
    beat_cnt_d    = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d       = ARB_BUSY;
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          beat_cnt_d    = '0;
        end
      end
      ARB_BUSY: begin
        if (tenure_end) begin
          ptr_d      = grant_idx_q;
          beat_cnt_d = '0;
          if (pick_any) begin
            grant_idx_d = pick_idx;
          end else if (end_hold && !end_last) begin
            // Sole requester cut off by the hold limit keeps the bus.
            grant_idx_d = grant_idx_q;
          end else begin
            state_d       = ARB_IDLE;
            grant_idx_d   = '0;
            grant_valid_d = 1'b0;
          end
        end else if (bus_valid) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      ptr_q         <= 2'd3;
      beat_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      ptr_q         <= ptr_d;
      beat_cnt_q    <= beat_cnt_d;
    end
  end

endmodule
